// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Purpose : Shared 640x480@60 timing constants, the coordinate type used by the
//           sync generator and the sprite/number generators, and the decode
//           of a counter position into visible/hsync/vsync.
// Contents: H_*/V_* timing integers, coord_t, coord_t-typed boundary
//           constants, sync_sig_t bundle, SYNC_IDLE reset value,
//           sync_decode() helper.
// -----------------------------------------------------------------------------
package vga_pkg;

   // 10 bits covers both 0..799 and 0..524.
   typedef logic [9:0] coord_t;

   // Horizontal timing, in pixel ticks.
   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

   // Vertical timing, in lines.
   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Boundaries in the counter's own width so comparisons stay 10 bits wide.
   localparam coord_t H_ACTIVE_C     = coord_t'(H_ACTIVE);
   localparam coord_t H_SYNC_START_C = coord_t'(H_ACTIVE + H_FP);
   localparam coord_t H_SYNC_END_C   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
   localparam coord_t H_LAST_C       = coord_t'(H_TOTAL - 1);

   localparam coord_t V_ACTIVE_C     = coord_t'(V_ACTIVE);
   localparam coord_t V_SYNC_START_C = coord_t'(V_ACTIVE + V_FP);
   localparam coord_t V_SYNC_END_C   = coord_t'(V_ACTIVE + V_FP + V_SYNC);
   localparam coord_t V_LAST_C       = coord_t'(V_TOTAL - 1);

   // The three position-derived signals travel together through the delay line.
   typedef struct packed {
      logic visible;
      logic hsync;   // active low
      logic vsync;   // active low
   } sync_sig_t;

   // Blanked, syncs deasserted: the value seen out of reset.
   localparam sync_sig_t SYNC_IDLE = '{visible: 1'b0, hsync: 1'b1, vsync: 1'b1};

   // Decode one counter position into its blanking/sync levels.
   function automatic sync_sig_t sync_decode(input coord_t col, input coord_t row);
      sync_sig_t s;
      s.visible = (col < H_ACTIVE_C) && (row < V_ACTIVE_C);
      s.hsync   = !((col >= H_SYNC_START_C) && (col < H_SYNC_END_C));
      s.vsync   = !((row >= V_SYNC_START_C) && (row < V_SYNC_END_C));
      return s;
   endfunction

endpackage : vga_pkg

// File: rtl/sync_delay_line.sv
// -----------------------------------------------------------------------------
// sync_delay_line
// Purpose : Enable-gated shift register of DEPTH stages, WIDTH bits each.
//           Every stage loads RESET_VAL on reset. DEPTH=0 is a plain wire.
// Ports   : clk       - system clock, rising edge
//           reset     - asynchronous, active high
//           i_en      - advance all stages by one (pixel tick)
//           i_data    - value entering stage 0
//           o_data    - value leaving the last stage (i_data when DEPTH=0)
// -----------------------------------------------------------------------------
module sync_delay_line #(
   parameter int                DEPTH     = 0,
   parameter int                WIDTH     = 1,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data
);

   generate
      if (DEPTH == 0) begin : g_bypass
         assign o_data = i_data;

         // Clock, reset and enable have no load in the zero-depth build.
         logic w_unused;
         assign w_unused = &{1'b0, clk, reset, i_en};
      end else begin : g_shift
         logic [WIDTH-1:0] r_stage [DEPTH];

         // NOTE: every stage is reset here, unlike a RAM, because downstream
         // logic must see the idle value for the first DEPTH ticks after reset.
         // NOTE: non-blocking assignments let every stage sample the previous
         // stage's old value, which is what makes this a shift and not a copy.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int i = 0; i < DEPTH; i++) begin
                  r_stage[i] <= RESET_VAL;
               end
            end else if (i_en) begin
               r_stage[0] <= i_data;
               for (int i = 1; i < DEPTH; i++) begin
                  r_stage[i] <= r_stage[i-1];
               end
            end
         end

         assign o_data = r_stage[DEPTH-1];
      end
   endgenerate

endmodule : sync_delay_line

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
// Purpose : 640x480 VGA timing generator. A clock divider produces a pixel
//           strobe; column/row counters advance on it; visible/hsync/vsync are
//           decoded from the counters and optionally delayed by SYNC_DLY ticks
//           to line up with a pipelined pixel path. col/row are never delayed.
// Params  : CLK_DIV  - system clocks per pixel (1..8)
//           SYNC_DLY - pixel ticks of delay on visible/hsync/vsync (0..3)
// Ports   : clk         - system clock, rising edge
//           reset       - asynchronous, active high
//           pix_tick    - one-clk pixel-advance strobe (always high if CLK_DIV=1)
//           col, row    - counters 0..799 / 0..524
//           visible     - inside the 640x480 active area
//           hsync/vsync - active-low sync
//           line_start  - one clk, first clk with col==0
//           frame_start - one clk, first clk with col==0 and row==0
// -----------------------------------------------------------------------------
module vga_sync_gen
   import vga_pkg::*;
#(
   parameter int CLK_DIV  = 2,
   parameter int SYNC_DLY = 0
) (
   input  logic   clk,
   input  logic   reset,
   output logic   pix_tick,
   output coord_t col,
   output coord_t row,
   output logic   visible,
   output logic   hsync,
   output logic   vsync,
   output logic   line_start,
   output logic   frame_start
);

   // ------------------------------------------------------------------
   // Pixel clock divider
   // ------------------------------------------------------------------
   localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] w_div_next;
   logic             r_pix_tick;

   // NOTE: each always_comb output gets a default before any branch so no
   // path leaves it unassigned; a missed branch would otherwise infer a latch.
   always_comb begin
      w_div_next = r_div + 1'b1;
      if (r_div == DIV_LAST) begin
         w_div_next = '0;
      end
   end

   // The strobe is registered from the next count, so it is high exactly in
   // the cycle where r_div == CLK_DIV-1. With CLK_DIV=1 the count is pinned
   // at 0 and the strobe stays high from the first clock after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_div      <= '0;
         r_pix_tick <= 1'b0;
      end else begin
         r_div      <= w_div_next;
         r_pix_tick <= (w_div_next == DIV_LAST);
      end
   end

   // ------------------------------------------------------------------
   // Column / row counters
   // ------------------------------------------------------------------
   coord_t    r_col;
   coord_t    r_row;
   coord_t    w_col_next;
   coord_t    w_row_next;
   sync_sig_t r_sync;
   sync_sig_t w_sync_next;
   logic      r_line_start;
   logic      r_frame_start;

   always_comb begin
      w_col_next = r_col;
      w_row_next = r_row;
      if (r_pix_tick) begin
         if (r_col == H_LAST_C) begin
            w_col_next = '0;
            w_row_next = (r_row == V_LAST_C) ? '0 : r_row + 1'b1;
         end else begin
            w_col_next = r_col + 1'b1;
         end
      end
   end

   // Decoding the next position and registering it keeps visible/hsync/vsync
   // cycle-aligned with col/row instead of one clock behind them.
   always_comb begin
      w_sync_next = sync_decode(w_col_next, w_row_next);
   end

   // Reset parks the counters on the last position of the frame so the first
   // tick wraps to (0,0) and raises frame_start like any later frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_col         <= H_LAST_C;
         r_row         <= V_LAST_C;
         r_sync        <= SYNC_IDLE;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_col         <= w_col_next;
         r_row         <= w_row_next;
         if (r_pix_tick) begin
            r_sync <= w_sync_next;
         end
         // Pulses last one clk even when ticks are further apart.
         r_line_start  <= r_pix_tick && (w_col_next == '0);
         r_frame_start <= r_pix_tick && (w_col_next == '0) && (w_row_next == '0);
      end
   end

   // ------------------------------------------------------------------
   // Optional alignment delay on the decoded sync bundle
   // ------------------------------------------------------------------
   sync_sig_t w_sync_out;

   sync_delay_line #(
      .DEPTH     (SYNC_DLY),
      .WIDTH     ($bits(sync_sig_t)),
      .RESET_VAL (SYNC_IDLE)
   ) u_sync_delay (
      .clk    (clk),
      .reset  (reset),
      .i_en   (r_pix_tick),
      .i_data (r_sync),
      .o_data (w_sync_out)
   );

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign pix_tick    = r_pix_tick;
   assign col         = r_col;
   assign row         = r_row;
   assign visible     = w_sync_out.visible;
   assign hsync       = w_sync_out.hsync;
   assign vsync       = w_sync_out.vsync;
   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;

endmodule : vga_sync_gen

// File: tb/tb_vga_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_gen
// Three generators share one clock: A (CLK_DIV=2, SYNC_DLY=0), B (CLK_DIV=2,
// SYNC_DLY=2, same reset as A so it runs in lock-step), C (CLK_DIV=1).
// A and B cover start-up, the first line and a mid-frame reset; C runs one
// whole frame for the frame-level totals and the vertical sync window.
// -----------------------------------------------------------------------------
module tb_vga_sync_gen;
   import vga_pkg::*;

   logic   clk;
   logic   rst_ab;
   logic   rst_c;

   logic   a_pix, a_vis, a_hs, a_vs, a_ls, a_fs;
   coord_t a_col, a_row;
   logic   b_pix, b_vis, b_hs, b_vs, b_ls, b_fs;
   coord_t b_col, b_row;
   logic   c_pix, c_vis, c_hs, c_vs, c_ls, c_fs;
   coord_t c_col, c_row;

   vga_sync_gen #(.CLK_DIV(2), .SYNC_DLY(0)) u_dut_a (
      .clk(clk), .reset(rst_ab), .pix_tick(a_pix), .col(a_col), .row(a_row),
      .visible(a_vis), .hsync(a_hs), .vsync(a_vs),
      .line_start(a_ls), .frame_start(a_fs)
   );

   vga_sync_gen #(.CLK_DIV(2), .SYNC_DLY(2)) u_dut_b (
      .clk(clk), .reset(rst_ab), .pix_tick(b_pix), .col(b_col), .row(b_row),
      .visible(b_vis), .hsync(b_hs), .vsync(b_vs),
      .line_start(b_ls), .frame_start(b_fs)
   );

   vga_sync_gen #(.CLK_DIV(1), .SYNC_DLY(0)) u_dut_c (
      .clk(clk), .reset(rst_c), .pix_tick(c_pix), .col(c_col), .row(c_row),
      .visible(c_vis), .hsync(c_hs), .vsync(c_vs),
      .line_start(c_ls), .frame_start(c_fs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // ---------------- running statistics, updated every sampled clock -------
   int     cyc = 0;
   // A / B
   int     ab_diff = 0;
   int     a_hold_err = 0;
   logic   a_fs_seen = 1'b0;
   logic   a_prev_valid = 1'b0;
   logic   a_prev_pix, a_prev_vis, a_prev_hs, a_prev_vs;
   coord_t a_prev_col, a_prev_row;
   int     a_l0_hs_low = 0, a_l0_hs_first = -1, a_l0_hs_last = -1;
   int     a_l0_vis = 0, a_l0_ls = 0;
   int     b_hs_first = -1, b_vis_fall = -1, b_vis_rise = -1;
   logic   b_prev_vis = 1'b0;
   // C
   int     c_pix_low = 0, c_ticks = 0, c_fs_n = 0;
   int     c_tick_fs1 = 0, c_tick_fs2 = 0;
   logic   c_in_frame = 1'b0;
   int     c_ls_n = 0, c_vis_n = 0, c_vs_low = 0;
   int     c_vs_first_row = -1, c_vs_first_col = -1;
   int     c_adv_err = 0;
   logic   c_fwrap_ok = 1'b0;
   logic   c_prev_valid = 1'b0;
   int     c_prev_col, c_prev_row;

   task automatic step();
      int exp_col, exp_row;
      @(negedge clk);
      cyc++;

      // ---- A / B ----
      if (a_col !== b_col || a_row !== b_row) ab_diff++;
      if (a_fs) a_fs_seen = 1'b1;
      if (a_prev_valid && !a_prev_pix && !rst_ab) begin
         if (a_col !== a_prev_col || a_row !== a_prev_row || a_vis !== a_prev_vis ||
             a_hs !== a_prev_hs || a_vs !== a_prev_vs) a_hold_err++;
      end
      a_prev_valid = !rst_ab;
      a_prev_pix = a_pix; a_prev_col = a_col; a_prev_row = a_row;
      a_prev_vis = a_vis; a_prev_hs = a_hs; a_prev_vs = a_vs;

      // first line of the first frame after release
      if (a_fs_seen && a_row == 10'd0 && cyc < 5000) begin
         if (a_ls) a_l0_ls++;
         if (a_pix) begin
            if (a_vis) a_l0_vis++;
            if (!a_hs) begin
               a_l0_hs_low++;
               if (a_l0_hs_first < 0) a_l0_hs_first = int'(a_col);
               a_l0_hs_last = int'(a_col);
            end
         end
         if (b_pix) begin
            if (!b_hs && b_hs_first < 0) b_hs_first = int'(b_col);
            if (!b_prev_vis && b_vis && b_vis_rise < 0) b_vis_rise = int'(b_col);
            if (b_prev_vis && !b_vis && b_vis_fall < 0) b_vis_fall = int'(b_col);
            b_prev_vis = b_vis;
         end
      end

      // ---- C ----
      if (!rst_c) begin
         if (!c_pix) c_pix_low++;
         if (c_pix) c_ticks++;
         if (c_prev_valid) begin
            exp_col = (c_prev_col == 799) ? 0 : c_prev_col + 1;
            exp_row = c_prev_row;
            if (c_prev_col == 799) exp_row = (c_prev_row == 524) ? 0 : c_prev_row + 1;
            if (int'(c_col) != exp_col || int'(c_row) != exp_row) c_adv_err++;
         end
         if (c_fs) begin
            c_fs_n++;
            if (c_fs_n == 1) begin
               c_tick_fs1 = c_ticks;
               c_in_frame = 1'b1;
            end else if (c_fs_n == 2) begin
               c_tick_fs2 = c_ticks;
               c_in_frame = 1'b0;
               c_fwrap_ok = (c_prev_col == 799) && (c_prev_row == 524) &&
                            (c_col == 10'd0) && (c_row == 10'd0) && c_ls;
            end
         end
         if (c_in_frame) begin
            if (c_ls) c_ls_n++;
            if (c_vis) c_vis_n++;
            if (!c_vs) begin
               c_vs_low++;
               if (c_vs_first_row < 0) begin
                  c_vs_first_row = int'(c_row);
                  c_vs_first_col = int'(c_col);
               end
            end
         end
         c_prev_col = int'(c_col);
         c_prev_row = int'(c_row);
         c_prev_valid = 1'b1;
      end
   endtask

   initial begin
      int guard;
      rst_ab = 1'b1;
      rst_c  = 1'b1;
      repeat (3) @(negedge clk);

      // ---------------- reset state ----------------
      check("a_rst_col",  a_col, 799);
      check("a_rst_row",  a_row, 524);
      check("a_rst_vis",  a_vis, 0);
      check("a_rst_hs",   a_hs,  1);
      check("a_rst_vs",   a_vs,  1);
      check("a_rst_pix",  a_pix, 0);
      check("a_rst_ls",   a_ls,  0);
      check("a_rst_fs",   a_fs,  0);
      check("b_rst_vis",  b_vis, 0);
      check("b_rst_hs",   b_hs,  1);
      check("b_rst_vs",   b_vs,  1);
      check("c_rst_pix",  c_pix, 0);
      check("c_rst_col",  c_col, 799);

      // ---------------- start-up after release ----------------
      rst_ab = 1'b0;
      rst_c  = 1'b0;
      step();  // clk 1
      check("a_c1_pix", a_pix, 1);
      check("a_c1_col", a_col, 799);
      check("a_c1_fs",  a_fs,  0);
      check("c_c1_pix", c_pix, 1);
      check("c_c1_col", c_col, 799);
      step();  // clk 2
      check("a_c2_pix", a_pix, 0);
      check("a_c2_fs",  a_fs,  1);
      check("a_c2_ls",  a_ls,  1);
      check("a_c2_col", a_col, 0);
      check("a_c2_row", a_row, 0);
      check("a_c2_vis", a_vis, 1);
      check("b_c2_vis", b_vis, 0);
      check("c_c2_fs",  c_fs,  1);
      check("c_c2_col", c_col, 0);
      check("c_c2_row", c_row, 0);
      step();  // clk 3
      check("a_c3_pix", a_pix, 1);
      check("a_c3_fs",  a_fs,  0);
      check("a_c3_ls",  a_ls,  0);
      check("a_c3_col", a_col, 0);
      check("c_c3_col", c_col, 1);
      check("c_c3_fs",  c_fs,  0);
      step();  // clk 4
      check("a_c4_pix", a_pix, 0);
      check("a_c4_col", a_col, 1);

      // ---------------- run A to (300,200), between ticks ----------------
      guard = 0;
      while (!(a_col == 10'd300 && a_row == 10'd200 && !a_pix) && guard < 400000) begin
         step();
         guard++;
      end
      check("a_reach_mid", (a_col == 10'd300 && a_row == 10'd200), 1);

      // first-line results are complete by now
      check("a_l0_hs_low",   a_l0_hs_low,   96);
      check("a_l0_hs_first", a_l0_hs_first, 656);
      check("a_l0_hs_last",  a_l0_hs_last,  751);
      check("a_l0_vis",      a_l0_vis,      640);
      check("a_l0_ls",       a_l0_ls,       1);
      check("b_hs_first",    b_hs_first,    658);
      check("b_vis_rise",    b_vis_rise,    2);
      check("b_vis_fall",    b_vis_fall,    642);

      // ---------------- asynchronous mid-frame reset ----------------
      rst_ab = 1'b1;
      #1;
      check("a_mid_col", a_col, 799);
      check("a_mid_row", a_row, 524);
      check("a_mid_vis", a_vis, 0);
      check("a_mid_hs",  a_hs,  1);
      check("a_mid_vs",  a_vs,  1);
      check("a_mid_pix", a_pix, 0);
      check("a_mid_ls",  a_ls,  0);
      check("a_mid_fs",  a_fs,  0);
      check("b_mid_vis", b_vis, 0);
      check("b_mid_hs",  b_hs,  1);
      check("b_mid_vs",  b_vs,  1);
      step();
      step();
      rst_ab = 1'b0;
      step();
      check("a_re1_pix", a_pix, 1);
      check("a_re1_fs",  a_fs,  0);
      step();
      check("a_re2_fs",  a_fs,  1);
      check("a_re2_col", a_col, 0);
      check("a_re2_row", a_row, 0);

      // ---------------- finish C's full frame ----------------
      guard = 0;
      while (c_fs_n < 2 && guard < 200000) begin
         step();
         guard++;
      end
      check("c_second_fs",    c_fs_n, 2);
      check("c_frame_ticks",  c_tick_fs2 - c_tick_fs1, 420000);
      check("c_frame_ls",     c_ls_n,  525);
      check("c_frame_vis",    c_vis_n, 307200);
      check("c_vs_low",       c_vs_low, 1600);
      check("c_vs_first_row", c_vs_first_row, 490);
      check("c_vs_first_col", c_vs_first_col, 0);
      check("c_pix_low",      c_pix_low, 0);
      check("c_advance_err",  c_adv_err, 0);
      check("c_frame_wrap",   c_fwrap_ok, 1);
      check("ab_col_row_diff", ab_diff, 0);
      check("a_hold_err",     a_hold_err, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_vga_sync_gen

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 2, meaning system clocks per pixel (legal 1..8).
REQ-002 The block SHALL have parameter SYNC_DLY, default 0, meaning pixel ticks of delay applied to hsync/vsync/visible only (legal 0..3).
REQ-003 The block SHALL have port clk, input, 1, single system clock; all logic rising-edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port pix_tick, output, 1, one-clk pixel-advance strobe.
REQ-006 The block SHALL have port col, output, 10, horizontal counter, 0..799.
REQ-007 The block SHALL have port row, output, 10, vertical counter, 0..524.
REQ-008 The block SHALL have port visible, output, 1, high inside the 640x480 active area.
REQ-009 The block SHALL have ports hsync and vsync, outputs, 1 each, active-low sync.
REQ-010 The block SHALL have ports line_start and frame_start, outputs, 1 each, one-clk pulses.

Function
REQ-011 The divider SHALL count 0..CLK_DIV-1 and assert pix_tick in the clk cycle where the count equals CLK_DIV-1; pix_tick SHALL stay constantly high when CLK_DIV=1.
REQ-012 On each clk edge with pix_tick high, col SHALL increment, wrapping 799->0; on that wrap, row SHALL increment, wrapping 524->0.
REQ-013 Horizontal timing SHALL be 640 active, 16 front porch, 96 sync, 48 back porch (total 800); vertical timing SHALL be 480, 10, 2, 33 (total 525).
REQ-014 For SYNC_DLY=0, visible SHALL equal (col<640 && row<480) for the current counter values, registered and cycle-aligned with col/row.
REQ-015 For SYNC_DLY=0, hsync SHALL be 0 exactly for 656<=col<752, and vsync SHALL be 0 exactly for 490<=row<492.
REQ-016 For SYNC_DLY=N>0, visible/hsync/vsync SHALL present the values belonging to the counter state N pixel ticks earlier, with shift stages advancing only on pix_tick.
REQ-017 col/row SHALL never be delayed by SYNC_DLY.
REQ-018 line_start SHALL pulse for exactly one clk, the first clk in which col==0.
REQ-019 frame_start SHALL pulse for exactly one clk, the first clk in which col==0 and row==0; line_start SHALL pulse in the same cycle.
REQ-020 Between pix_tick strobes, all outputs except pix_tick SHALL hold.
REQ-021 The counter widths SHALL be exactly 10 bits, with no intermediate values outside 0..799 and 0..524.

Reset
REQ-022 Reset SHALL set divider=0, col=799, row=524, visible=0, hsync=1, vsync=1, pix_tick=0, line_start=0, frame_start=0.
REQ-023 Reset SHALL fill every delay-line stage with the values visible=0, hsync=1, vsync=1.
REQ-024 After reset release, the first pix_tick SHALL move the counters to (0,0) and raise frame_start in the following clk.
REQ-025 A reset asserted mid-frame SHALL take effect immediately (asynchronously), without waiting for a pix_tick.

Structure
REQ-026 Package vga_pkg SHALL hold the timing constants (H_ACTIVE, H_FP, H_SYNC, H_BP, H_TOTAL and V_ equivalents) and the typedef coord_t (logic [9:0]) shared with the sprite/number generators.
REQ-027 The SYNC_DLY shift register SHALL be a sub-module sync_delay_line, parameterised by depth and width, with enable=pix_tick; depth 0 SHALL be a pass-through.

Verification
REQ-028 The bench SHALL cover this scenario: CLK_DIV=2, release reset -> pix_tick at clk 1,3,5,...; frame_start in the clk after the first pix_tick, with col=0 and row=0.
REQ-029 The bench SHALL cover this scenario: run one full frame -> exactly 420000 pix_ticks between frame_starts, 525 line_starts, 307200 ticks with visible=1.
REQ-030 The bench SHALL cover this scenario: sample hsync over one line -> low for 96 ticks starting at col=656; vsync low for 1600 ticks starting at row=490, col=0.
REQ-031 The bench SHALL cover this scenario: SYNC_DLY=2 -> hsync falls when col=658, visible falls when col=642, col/row identical to the SYNC_DLY=0 run.
REQ-032 The bench SHALL cover this scenario: assert reset at col=300, row=200 between ticks -> outputs match REQ-022 in the same cycle; restart gives frame_start after the first tick.
REQ-033 The bench SHALL cover this scenario: CLK_DIV=1 -> pix_tick constantly high, col advances every clk, wrap 799->0 increments row, and 524/799 wraps to 0/0 with frame_start.
